// File: rtl/mul_pkg.sv
// Shared widths and FSM encoding for the sequential 7x7 multiplier.
package mul_pkg;

  localparam int MUL_W  = 7;
  localparam int PROD_W = 14;
  localparam int CNT_W  = 3;

  // Index of the last multiplier bit processed in RUN.
  localparam logic [CNT_W-1:0] LAST_BIT = 3'd6;

  // 2'd3 is unused and falls back to IDLE on the next edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_ctrl_if.sv
// Operand / result handshake bundle between source, multiplier and consumer.
interface seq_mul_ctrl_if;
  import mul_pkg::*;

  logic              start;
  logic [MUL_W-1:0]  A;
  logic [MUL_W-1:0]  B;
  logic              ready;
  logic              busy;
  logic              out_valid;
  logic              out_ack;
  logic [PROD_W-1:0] P;

  // Operand source and result consumer side.
  modport master (
    output start, A, B, out_ack,
    input  ready, busy, out_valid, P
  );

  // Multiplier side.
  modport slave (
    input  start, A, B, out_ack,
    output ready, busy, out_valid, P
  );

endinterface

// File: rtl/seq_mul_ctrl_partial_mul.sv
// One partial-product row: the multiplicand gated by a single multiplier bit.
module partial_mul
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] A,
  input  logic             b,
  output logic [MUL_W-1:0] P
);

  assign P = A & {MUL_W{b}};

endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequential 7x7 unsigned shift-add multiplier: one partial-product row is
// reused for each multiplier bit, one bit per cycle, into a 14-bit accumulator.
module seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst,
  seq_mul_ctrl_if.slave  bus
);

  state_t             state;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [CNT_W-1:0]   cnt;
  logic [PROD_W-1:0]  acc;
  logic [PROD_W-1:0]  acc_next;
  logic [PROD_W-1:0]  p_r;
  logic [W-1:0]       pp;

  // Zero-extend a partial-product row and move it to the weight of bit sh.
  // The largest product is 127*127 < 2^14, so no bits are ever lost.
  function automatic logic [PROD_W-1:0] align_pp(input logic [W-1:0] row,
                                                 input logic [CNT_W-1:0] sh);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-W){1'b0}}, row};
    return ext << sh;
  endfunction

  partial_mul u_partial_mul (
    .A (a_r),
    .b (b_r[cnt]),
    .P (pp)
  );

  // Accumulator update for the current multiplier bit.
  always_comb begin
    acc_next = acc + align_pp(pp, cnt);
  end

  // Control FSM together with operand latches, bit counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      cnt   <= '0;
      acc   <= '0;
      p_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r   <= bus.A;
            b_r   <= bus.B;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == LAST_BIT) begin
            p_r   <= acc_next;
            state <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches them combinationally.
  assign bus.ready     = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.P         = p_r;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed and randomized bench for seq_mul_ctrl; expected products come from
// plain integer multiplication of the operands handed to the DUT.
module tb_seq_mul_ctrl;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mul_ctrl_if bus ();

  seq_mul_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: the product is simply a*b for 7-bit unsigned operands.
  function automatic int ref_product(input int a, input int b);
    return a * b;
  endfunction

  // Issue one multiply from IDLE, wait out RUN, check the result, ack after
  // ack_delay DONE cycles. With poke set, start=1 and A/B=1 are driven during RUN.
  task automatic run_mul(input string tag, input int a, input int b,
                         input int ack_delay, input bit poke);
    int n;
    logic [31:0] av, bv;
    av = a;
    bv = b;
    bus.start = 1'b1;
    bus.A = av[6:0];
    bus.B = bv[6:0];
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      if (poke) begin
        bus.start = 1'b1;
        bus.A = 7'd1;
        bus.B = 7'd1;
      end
      n++;
      tick();
    end
    bus.start = 1'b0;
    check({tag, " busy cycles"}, n, 7);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 1);
    check({tag, " P"}, {18'd0, bus.P}, ref_product(a, b));
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check({tag, " valid hold"}, {31'd0, bus.out_valid}, 1);
      check({tag, " P hold"}, {18'd0, bus.P}, ref_product(a, b));
    end
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    check({tag, " ready after ack"}, {31'd0, bus.ready}, 1);
    tick();
    check({tag, " no extra op"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    int n;
    int vcnt;
    int ra, rb, rd;

    bus.start   = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.out_ack = 1'b0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("reset ready", {31'd0, bus.ready}, 1);
    check("reset busy", {31'd0, bus.busy}, 0);
    check("reset out_valid", {31'd0, bus.out_valid}, 0);
    check("reset P", {18'd0, bus.P}, 0);

    // Idle with start low: nothing moves.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) n++;
    end
    check("idle stable", n, 0);

    // 5*3 with out_ack held high throughout.
    bus.out_ack = 1'b1;
    bus.A = 7'd5;
    bus.B = 7'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("5x3 busy cycles", n, 7);
    check("5x3 P", {18'd0, bus.P}, ref_product(5, 3));
    vcnt = 0;
    while (bus.out_valid === 1'b1 && vcnt < 20) begin
      vcnt++;
      tick();
    end
    check("5x3 valid cycles", vcnt, 1);
    check("5x3 ready after", {31'd0, bus.ready}, 1);
    bus.out_ack = 1'b0;
    tick();

    // Full-scale operands with a held-off consumer.
    run_mul("127x127", 127, 127, 5, 1'b0);

    // start and operand changes during RUN are ignored.
    run_mul("100x77", 100, 77, 0, 1'b1);

    // Reset in the 4th RUN cycle aborts the multiply.
    bus.A = 7'd9;
    bus.B = 7'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("mid-run busy", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", {31'd0, bus.ready}, 1);
    check("abort busy", {31'd0, bus.busy}, 0);
    check("abort P", {18'd0, bus.P}, 0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid === 1'b1) vcnt++;
      tick();
    end
    check("abort no valid", vcnt, 0);
    run_mul("0x99", 0, 99, 0, 1'b0);

    // Ack and start in the same DONE cycle: only the return to IDLE happens.
    bus.A = 7'd3;
    bus.B = 7'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("3x7 reached done", {31'd0, bus.out_valid}, 1);
    check("3x7 P", {18'd0, bus.P}, ref_product(3, 7));
    bus.out_ack = 1'b1;
    bus.start = 1'b1;
    bus.A = 7'd2;
    bus.B = 7'd64;
    tick();
    bus.out_ack = 1'b0;
    check("ack+start ready", {31'd0, bus.ready}, 1);
    check("ack+start not busy", {31'd0, bus.busy}, 0);
    run_mul("2x64", 2, 64, 0, 1'b0);

    // Randomized operands and consumer delays against the integer model.
    for (int k = 0; k < 8; k++) begin
      ra = int'($urandom_range(0, 127));
      rb = int'($urandom_range(0, 127));
      rd = int'($urandom_range(0, 3));
      run_mul($sformatf("rand%0d", k), ra, rb, rd, k[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_mul_ctrl.md
# seq_mul_ctrl

Sequential 7×7 unsigned shift-add multiplier controller. It time-shares one `partial_mul` AND-row across the seven multiplier bits, one bit per cycle, and accumulates into a 14-bit product. It sits between an operand source (start/ready handshake) and a result consumer (valid/ack handshake). It replaces a full array of seven partial-product rows where area matters more than latency.

## Interface
Parameters:
- `W`, 7: operand width. Fixed at 7 to match `partial_mul`; not a free parameter, must not be overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request to begin a multiply; sampled only when `ready`=1.
- `A`  in  7  multiplicand; latched on the accepted `start`.
- `B`  in  7  multiplier; latched on the accepted `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in RUN only.
- `out_valid`  out  1  high in DONE only; `P` is valid while high.
- `out_ack`  in  1  consumer accepts `P`; sampled only when `out_valid`=1.
- `P`  out  14  product A×B, unsigned.

## Operation
- FSM states: IDLE, RUN, DONE. `ready`, `busy` and `out_valid` decode directly from state and are mutually exclusive.
- IDLE with `start`=1:
  - latch A→`a_r` and B→`b_r`
  - clear `acc` to 0 and `cnt` to 0
  - go to RUN.
- IDLE with `start`=0: hold.
- RUN, each cycle:
  - `pp` = `partial_mul(a_r, b_r[cnt])`, 7 bits.
  - `acc` ← `acc` + ({7'b0,`pp`} << `cnt`), 14-bit add.
  - if `cnt`=6: go to DONE; `P` ← the updated `acc` value.
  - otherwise `cnt` ← `cnt`+1.
- Arithmetic: the maximum product is 127×127 = 16129 < 2^14, so no overflow and no carry-out is needed. `cnt` is 3 bits and never exceeds 6.
- DONE: hold `P`. `out_ack`=1 → IDLE. `out_ack`=0 → stay in DONE indefinitely.
- `start` asserted in RUN or DONE is ignored. It is not queued.
- A and B changing after acceptance have no effect, because the operands are latched.
- DONE with `out_ack`=1 and `start`=1 in the same cycle: return to IDLE only. `start` is not accepted that cycle, since `ready` was 0. A new multiply needs `start` in a later cycle.
- `out_ack` outside DONE is ignored.
- Zero operands still take the full 7 RUN cycles. There is no early termination.

## Timing
- Reset (`rst`=1 at an edge) forces:
  - state IDLE, so `ready`=1, `busy`=0, `out_valid`=0
  - `P`=0, `acc`=0, `cnt`=0, `a_r`=0, `b_r`=0.
- `rst` has priority over every other input, in any state. Reset mid-RUN aborts the operation and produces no `out_valid`.
- If `start` is accepted at edge k:
  - `busy` is high in the cycles after edges k through k+6 (7 cycles).
  - `out_valid` rises after edge k+7, and `P` is valid in that same cycle.
- Minimum issue interval is 9 cycles:
  - start edge, 7 RUN edges, ack edge
  - then the next `start` at the edge after returning to IDLE.
- All outputs are registered state or direct state decode. There is no combinational path from inputs to outputs.

## Structure
- Shared package `mul_pkg` holds:
  - `MUL_W` = 7
  - `PROD_W` = 14
  - the state encoding as localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 unused; it decodes to IDLE on the next edge).
- One sub-module, the existing `partial_mul`, instantiated once:
  - A ← `a_r`
  - b ← `b_r[cnt]`
  - P → `pp`.
- The shift, add and FSM live in `seq_mul_ctrl`.

## Test plan
- Reset then idle:
  - check `ready`=1, `busy`=0, `out_valid`=0, `P`=0.
  - `start`=0 for 20 cycles → no state change.
- A=5, B=3, `start` pulse, `out_ack` held 1:
  - `busy` high for exactly 7 cycles.
  - `out_valid` high for exactly 1 cycle with `P`=15.
  - `ready` high the following cycle.
- A=127, B=127:
  - `P`=16129 (14'h3F01).
  - Hold `out_ack`=0 for 5 cycles → `P` and `out_valid` stable, then ack → IDLE.
- A=100, B=77 → `P`=7700.
  - During RUN, drive `start`=1 and change A/B to 1/1 → result unaffected, and no second operation starts.
- Reset mid-RUN: start A=9, B=9, assert `rst` at the 4th RUN cycle:
  - next cycle IDLE, `P`=0, and no `out_valid` ever.
  - A new start with A=0, B=99 → `P`=0 after the full latency.
- DONE with `out_ack`=1 and `start`=1 together:
  - returns to IDLE and `start` is not accepted.
  - `start` one cycle later with A=2, B=64 → `P`=128.
